apb_master_arbiter: RTL

Two-requester APB master. It arbitrates round-robin between requesters 0 and 1 (for example, host config path and refresh/status poller) and runs one APB transfer at a time (SETUP then ACCESS) on the shared 16-bit bus. It returns read data and an error status to the winning requester, and enforces a pready timeout so that a hung slave cannot lock the bus.

---
 rtl/apb_master_arbiter.sv | 116 +++++++++++
 1 files changed

// File: rtl/apb_master_arbiter.sv
// Two-requester round-robin APB master with a pready timeout.
// state  | meaning
// IDLE   | bus free, arbitrating req_valid
// SETUP  | psel=1, penable=0, address phase
// ACCESS | psel=1, penable=1, waiting for pready or timeout
module apb_master_arbiter #(
  parameter int ADDR_W         = 16,
  parameter int DATA_W         = 16,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 8
) (
  input  logic                  pclk,
  input  logic                  preset,
  input  logic [1:0]            req_valid,
  input  logic [1:0]            req_write,
  input  logic [2*ADDR_W-1:0]   req_addr,
  input  logic [2*DATA_W-1:0]   req_wdata,
  output logic [1:0]            req_ready,
  output logic [1:0]            rsp_valid,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_err,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [ADDR_W-1:0]     paddr,
  output logic [DATA_W-1:0]     pwdata,
  input  logic [DATA_W-1:0]     prdata,
  input  logic                  pready,
  input  logic                  pslverr
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_e;

  localparam bit TMO_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  state_e             state_q;
  logic               last_grant_q;
  logic               owner_q;
  logic [CNT_W-1:0]   cnt_q;

  logic               win_d;
  logic               wr_d;
  logic [ADDR_W-1:0]  addr_d;
  logic [DATA_W-1:0]  wdata_d;
  logic               tmo_d;

  // On a tie the requester that did not win last time is chosen.
  always_comb begin
    win_d   = (req_valid == 2'b11) ? ~last_grant_q : req_valid[1];
    wr_d    = win_d ? req_write[1] : req_write[0];
    addr_d  = win_d ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
    wdata_d = '0;
    if (wr_d) wdata_d = win_d ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
    tmo_d   = TMO_EN && (cnt_q == CNT_LAST);
  end

  always_ff @(posedge pclk) begin
    if (!preset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      cnt_q        <= '0;
      req_ready    <= '0;
      rsp_valid    <= '0;
      rsp_rdata    <= '0;
      rsp_err      <= 1'b0;
      psel         <= 1'b0;
      penable      <= 1'b0;
      pwrite       <= 1'b0;
      paddr        <= '0;
      pwdata       <= '0;
    end else begin
      req_ready <= '0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (|req_valid) begin
            owner_q   <= win_d;
            paddr     <= addr_d;
            pwrite    <= wr_d;
            pwdata    <= wdata_d;
            psel      <= 1'b1;
            penable   <= 1'b0;
            req_ready <= win_d ? 2'b10 : 2'b01;
            state_q   <= SETUP;
          end
        end
        SETUP: begin
          penable <= 1'b1;
          cnt_q   <= '0;
          state_q <= ACCESS;
        end
        ACCESS: begin
          // A timed-out transfer completes like a normal one but reports an error.
          if (pready || tmo_d) begin
            rsp_valid    <= owner_q ? 2'b10 : 2'b01;
            rsp_err      <= pready ? pslverr : 1'b1;
            rsp_rdata    <= (pready && !pwrite) ? prdata : '0;
            psel         <= 1'b0;
            penable      <= 1'b0;
            last_grant_q <= owner_q;
            state_q      <= IDLE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
